// File: rtl/int_to_float_pkg.sv
// Shared constants and the 13-bit float layout used by int_to_float_converter.
// Optional feature macro: INT_TO_FLOAT_UNSIGNED_EN (see int_to_float_converter.sv).
package int_to_float_pkg;

    localparam int INT_W  = 8;
    localparam int EXP_W  = 4;
    localparam int FRAC_W = 8;

    // Value = (-1)^sign * 0.frac * 2^exp; frac MSB is 1 for every non-zero value.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float13_t;

    localparam float13_t FLOAT_ZERO = '{sign: 1'b0, exp: '0, frac: '0};

endpackage

// File: rtl/int_to_float_leading_one_detector.sv
// Combinational priority encoder: position of the most significant set bit of
// an 8-bit vector, plus a flag for the all-zero vector (position is 0 then).
module leading_one_detector (
    input  logic [7:0] vec,
    output logic [2:0] pos,
    output logic       zero
);

    logic [7:0] is_lead;

    // A bit leads when it is set and nothing above it is set; exactly one
    // bit of is_lead is high for a non-zero input, so OR-ing indices is safe.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lead
            assign is_lead[gi] = vec[gi] & ~|(vec >> (gi + 1));
        end
    endgenerate

    always_comb begin
        pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (is_lead[i]) begin
                pos = pos | 3'(i);
            end
        end
    end

    assign zero = ~|vec;

endmodule

// File: rtl/int_to_float_converter.sv
// 8-bit two's-complement integer to 13-bit float, combinational plus a registered copy.
// Macro INT_TO_FLOAT_UNSIGNED_EN adds signed_i to select unsigned interpretation.
module int_to_float_converter
    import int_to_float_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
`ifdef INT_TO_FLOAT_UNSIGNED_EN
    input  logic             signed_i,
`endif
    input  logic [INT_W-1:0] int_i,
    output logic [12:0]      float_o,
    output logic [12:0]      float_r_o
);

    logic             sign_bit;
    logic [INT_W-1:0] mag;
    logic [2:0]       lead_pos;
    logic             mag_zero;
    float13_t         conv;
    float13_t         float_reg;

`ifdef INT_TO_FLOAT_UNSIGNED_EN
    assign sign_bit = signed_i & int_i[INT_W-1];
`else
    assign sign_bit = int_i[INT_W-1];
`endif

    // -128 negates to 8'h80, which is the correct unsigned magnitude.
    assign mag = sign_bit ? (~int_i + 8'd1) : int_i;

    leading_one_detector u_lod (
        .vec  (mag),
        .pos  (lead_pos),
        .zero (mag_zero)
    );

    always_comb begin
        conv = FLOAT_ZERO;
        if (!mag_zero) begin
            conv.sign = sign_bit;
            conv.exp  = {1'b0, lead_pos} + 4'd1;
            conv.frac = mag << (3'd7 - lead_pos);
        end
    end

    assign float_o = conv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            float_reg <= FLOAT_ZERO;
        end else begin
            float_reg <= conv;
        end
    end

    assign float_r_o = float_reg;

endmodule

// File: tb/tb_int_to_float_converter.sv
// Self-checking bench for int_to_float_converter: vector table, exhaustive sweep,
// random stimulus against an arithmetic model, and async reset sequences.
module tb_int_to_float_converter;

    logic        clk;
    logic        reset;
    logic        signed_sel;
    logic [7:0]  int_i;
    logic [12:0] float_o;
    logic [12:0] float_r_o;

    int checks;
    int errors;

    int_to_float_converter dut (
        .clk       (clk),
        .reset     (reset),
`ifdef INT_TO_FLOAT_UNSIGNED_EN
        .signed_i  (signed_sel),
`endif
        .int_i     (int_i),
        .float_o   (float_o),
        .float_r_o (float_r_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  in_val;
        logic        sgn;
        logic [12:0] expected;
    } vec_t;

    // Reference: value v, exponent = bit length of |v|, frac = |v| scaled to 8 bits.
    function automatic logic [12:0] model(input logic [7:0] x, input logic sgn);
        int v;
        int mag;
        int e;
        int frac;
        if (sgn && x[7]) v = int'(x) - 256;
        else             v = int'(x);
        if (v == 0) return 13'b0;
        mag = (v < 0) ? -v : v;
        e = 0;
        while ((1 << e) <= mag) e++;
        frac = mag * (1 << (8 - e));
        return {(v < 0) ? 1'b1 : 1'b0, 4'(e), 8'(frac)};
    endfunction

    function automatic int decode(input logic [12:0] f);
        int mag;
        mag = (int'(f[7:0]) << int'(f[11:8])) >> 8;
        return f[12] ? -mag : mag;
    endfunction

    function automatic int int_value(input logic [7:0] x, input logic sgn);
        if (sgn && x[7]) return int'(x) - 256;
        return int'(x);
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b_%b_%b expected %b_%b_%b", name,
                     act[12], act[11:8], act[7:0], exp_v[12], exp_v[11:8], exp_v[7:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Applies one operand, checks the combinational result, then the registered copy.
    task automatic apply_and_check(input string name, input logic [7:0] x, input logic sgn,
                                   input logic [12:0] exp_v);
        @(negedge clk);
        int_i      = x;
        signed_sel = sgn;
        #1;
        check({name, " comb"}, float_o, exp_v);
        @(posedge clk);
        #1;
        check({name, " reg"}, float_r_o, exp_v);
        $display("txn %s in=%h sgn=%0d float_o=%h float_r_o=%h", name, x, sgn, float_o, float_r_o);
    endtask

    vec_t vectors[$];

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        signed_sel = 1'b1;
        int_i      = 8'h05;

        vectors.push_back('{8'h00, 1'b1, 13'b0_0000_00000000});
        vectors.push_back('{8'h01, 1'b1, 13'b0_0001_10000000});
        vectors.push_back('{8'h05, 1'b1, 13'b0_0011_10100000});
        vectors.push_back('{8'h7F, 1'b1, 13'b0_0111_11111110});
        vectors.push_back('{8'h40, 1'b1, 13'b0_0111_10000000});
        vectors.push_back('{8'hFF, 1'b1, 13'b1_0001_10000000});
        vectors.push_back('{8'h80, 1'b1, 13'b1_1000_10000000});
        vectors.push_back('{8'hFB, 1'b1, 13'b1_0011_10100000});
        vectors.push_back('{8'hC0, 1'b1, 13'b1_0111_10000000});
`ifdef INT_TO_FLOAT_UNSIGNED_EN
        vectors.push_back('{8'hFF, 1'b0, 13'b0_1000_11111111});
        vectors.push_back('{8'h80, 1'b0, 13'b0_1000_10000000});
        vectors.push_back('{8'h05, 1'b0, 13'b0_0011_10100000});
`endif

        // Reset held across an edge: register stays zero, comb path still live.
        #2;
        check("reset state reg", float_r_o, 13'b0);
        @(posedge clk);
        #1;
        check("reset hold reg", float_r_o, 13'b0);
        check("comb during reset", float_o, 13'b0_0011_10100000);
        @(negedge clk);
        reset = 1'b0;

        foreach (vectors[i]) begin
            apply_and_check($sformatf("vec%0d", i), vectors[i].in_val, vectors[i].sgn,
                            vectors[i].expected);
        end

        // Exhaustive sweep with round-trip decode.
        for (int m = 0; m < 2; m++) begin
`ifndef INT_TO_FLOAT_UNSIGNED_EN
            if (m == 1) break;
`endif
            for (int i = 0; i < 256; i++) begin
                signed_sel = (m == 0) ? 1'b1 : 1'b0;
                int_i      = 8'(i);
                #1;
                check($sformatf("sweep m%0d %02h", m, i), float_o, model(int_i, signed_sel));
                check_int($sformatf("decode m%0d %02h", m, i), decode(float_o),
                          int_value(int_i, signed_sel));
            end
            $display("txn sweep mode %0d done", m);
        end

        // Random operands through both paths.
        for (int k = 0; k < 150; k++) begin
            logic [7:0] x;
            logic       s;
            x = 8'($urandom_range(0, 255));
`ifdef INT_TO_FLOAT_UNSIGNED_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b1;
`endif
            apply_and_check($sformatf("rand%0d", k), x, s, model(x, s));
        end

        // Asynchronous reset asserted between edges.
        apply_and_check("pre-reset", 8'h05, 1'b1, 13'b0_0011_10100000);
        #2;
        reset = 1'b1;
        #1;
        check("async reset immediate", float_r_o, 13'b0);
        @(posedge clk);
        #1;
        check("async reset holds", float_r_o, 13'b0);
        @(negedge clk);
        reset = 1'b0;
        int_i = 8'hFB;
        #1;
        check("no capture before edge", float_r_o, 13'b0);
        @(posedge clk);
        #1;
        check("first capture after reset", float_r_o, 13'b1_0011_10100000);
        $display("txn reset sequence float_r_o=%h", float_r_o);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
